// File: rtl/lpm_table_arbiter.sv
// lpm_table_arbiter
//   Owns the 32-entry longest-prefix-match route table. It arbitrates the
//   table between destination-IP lookups from the packet pipeline and
//   route writes/clears from the software register block.
//
//   Lookups run through a two-stage pipeline, one per cycle:
//     stage 1 (accept cycle) - compare against every entry, register the
//                              match vector and the IP.
//     stage 2                - priority-encode (lowest index wins), read the
//                              winning entry's fields, register the response.
//   A software request is committed in a one-cycle COMMIT state. Lookups
//   are paused there. A pending request can let at most MAX_WR_WAIT lookups
//   through before lookups are stalled, so software is never starved.
//
// Ports
//   AXI_ACLK, AXI_RESET        clock, synchronous active-high reset
//   lkup_req_valid/ready       lookup request handshake
//   lkup_ip                    destination IP to look up
//   lkup_resp_valid            one-cycle result pulse, two cycles after accept
//   lkup_hit/index/nh/oq       lookup result (all zero on a miss)
//   sw_wr_req                  software request, held until sw_wr_ack
//   sw_wr_clear                1 = invalidate every entry
//   sw_wr_index/valid/ip/mask/nh/oq   entry contents for a single-entry write
//   sw_wr_ack                  one-cycle pulse in the commit cycle
//   counter_reset              clears both statistics counters
//   lpm_hit_count/miss_count   wrapping response counters
//   dbg_state_commit           FSM state, high while in COMMIT
//
// Handshake: a lookup transfers in any cycle where lkup_req_valid and
// lkup_req_ready are both high. lkup_req_valid may be asserted without
// waiting for ready. lkup_ip is sampled only in the transfer cycle. Responses
// have no backpressure. sw_wr_req and its qualifiers stay stable until the
// sw_wr_ack cycle, and sw_wr_req drops in the cycle after the ack.

module lpm_table_arbiter #(
    parameter int NUM_ENTRIES = 32,
    parameter int MAX_WR_WAIT = 16
) (
    input  logic        AXI_ACLK,
    input  logic        AXI_RESET,
    input  logic        lkup_req_valid,
    output logic        lkup_req_ready,
    input  logic [31:0] lkup_ip,
    output logic        lkup_resp_valid,
    output logic        lkup_hit,
    output logic [4:0]  lkup_index,
    output logic [31:0] lkup_nh,
    output logic [31:0] lkup_oq,
    input  logic        sw_wr_req,
    input  logic        sw_wr_clear,
    input  logic [4:0]  sw_wr_index,
    input  logic        sw_wr_valid,
    input  logic [31:0] sw_wr_ip,
    input  logic [31:0] sw_wr_mask,
    input  logic [31:0] sw_wr_nh,
    input  logic [31:0] sw_wr_oq,
    output logic        sw_wr_ack,
    input  logic        counter_reset,
    output logic [31:0] lpm_hit_count,
    output logic [31:0] lpm_miss_count,
    output logic        dbg_state_commit
);

    localparam int WCW = $clog2(MAX_WR_WAIT + 1);

    typedef enum logic {
        RUN    = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t             state;
    logic [WCW-1:0]     wait_cnt;
    logic               wait_full;
    logic               lkup_accept;

    logic [NUM_ENTRIES-1:0] tbl_valid;
    logic [31:0]            tbl_ip   [NUM_ENTRIES];
    logic [31:0]            tbl_mask [NUM_ENTRIES];
    logic [31:0]            tbl_nh   [NUM_ENTRIES];
    logic [31:0]            tbl_oq   [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] match_vec;
    logic [NUM_ENTRIES-1:0] s1_match;
    logic [31:0]            s1_ip;
    logic                   s1_valid;

    logic                   enc_hit;
    logic [4:0]             enc_idx;
    logic [31:0]            enc_nh;
    logic [31:0]            enc_oq;

    assign wait_full        = (wait_cnt == WCW'(MAX_WR_WAIT));
    // A pending write that has already let MAX_WR_WAIT lookups through
    // blocks lookups in this cycle, so the FSM can take the commit slot.
    assign lkup_req_ready   = !AXI_RESET && (state == RUN) && !(sw_wr_req && wait_full);
    assign lkup_accept      = lkup_req_valid && lkup_req_ready;
    assign dbg_state_commit = (state == COMMIT);

    // Stage 1 compare against the whole table.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            match_vec[i] = tbl_valid[i] &&
                           ((lkup_ip & tbl_mask[i]) == (tbl_ip[i] & tbl_mask[i]));
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            s1_valid <= 1'b0;
            s1_match <= '0;
            s1_ip    <= '0;
        end else begin
            s1_valid <= lkup_accept;
            if (lkup_accept) begin
                s1_match <= match_vec;
                s1_ip    <= lkup_ip;
            end
        end
    end

    // Stage 2 priority encode. The loop runs from the top down, so the
    // lowest matching index is the last one assigned and wins.
    // A zero next hop marks a directly connected route, so the looked-up
    // address itself is the next hop.
    always_comb begin
        enc_hit = 1'b0;
        enc_idx = '0;
        enc_nh  = '0;
        enc_oq  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (s1_match[i]) begin
                enc_hit = 1'b1;
                enc_idx = 5'(i);
                enc_nh  = (tbl_nh[i] != 32'd0) ? tbl_nh[i] : s1_ip;
                enc_oq  = tbl_oq[i];
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            lkup_resp_valid <= 1'b0;
            lkup_hit        <= 1'b0;
            lkup_index      <= '0;
            lkup_nh         <= '0;
            lkup_oq         <= '0;
            lpm_hit_count   <= '0;
            lpm_miss_count  <= '0;
        end else begin
            lkup_resp_valid <= s1_valid;
            lkup_hit        <= s1_valid && enc_hit;
            lkup_index      <= (s1_valid && enc_hit) ? enc_idx : 5'd0;
            lkup_nh         <= (s1_valid && enc_hit) ? enc_nh  : 32'd0;
            lkup_oq         <= (s1_valid && enc_hit) ? enc_oq  : 32'd0;
            if (counter_reset) begin
                lpm_hit_count  <= '0;
                lpm_miss_count <= '0;
            end else if (s1_valid) begin
                if (enc_hit) lpm_hit_count  <= lpm_hit_count + 32'd1;
                else         lpm_miss_count <= lpm_miss_count + 32'd1;
            end
        end
    end

    // Arbitration FSM and table write port. The table is written at the end
    // of the COMMIT cycle, so a stage-2 read in that same cycle still sees
    // the old contents.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state     <= RUN;
            wait_cnt  <= '0;
            sw_wr_ack <= 1'b0;
            tbl_valid <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_ip[i]   <= '0;
                tbl_mask[i] <= '0;
                tbl_nh[i]   <= '0;
                tbl_oq[i]   <= '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (sw_wr_req && lkup_accept && !wait_full) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    if (sw_wr_req && (!lkup_req_valid || wait_full)) begin
                        state     <= COMMIT;
                        sw_wr_ack <= 1'b1;
                    end else begin
                        sw_wr_ack <= 1'b0;
                    end
                end
                COMMIT: begin
                    state     <= RUN;
                    sw_wr_ack <= 1'b0;
                    wait_cnt  <= '0;
                    if (sw_wr_clear) begin
                        tbl_valid <= '0;
                    end else begin
                        // Indices outside the table match no entry and are dropped.
                        for (int i = 0; i < NUM_ENTRIES; i++) begin
                            if (5'(i) == sw_wr_index) begin
                                tbl_valid[i] <= sw_wr_valid;
                                tbl_ip[i]    <= sw_wr_ip;
                                tbl_mask[i]  <= sw_wr_mask;
                                tbl_nh[i]    <= sw_wr_nh;
                                tbl_oq[i]    <= sw_wr_oq;
                            end
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_lpm_table_arbiter.sv
// Testbench for lpm_table_arbiter: directed steps and randomized lookups
// compared against a route-table reference model held in the bench.
module tb_lpm_table_arbiter;

    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lkup_req_valid = 1'b0;
    logic        lkup_req_ready;
    logic [31:0] lkup_ip = '0;
    logic        lkup_resp_valid;
    logic        lkup_hit;
    logic [4:0]  lkup_index;
    logic [31:0] lkup_nh;
    logic [31:0] lkup_oq;
    logic        sw_wr_req = 1'b0;
    logic        sw_wr_clear = 1'b0;
    logic [4:0]  sw_wr_index = '0;
    logic        sw_wr_valid = 1'b0;
    logic [31:0] sw_wr_ip = '0;
    logic [31:0] sw_wr_mask = '0;
    logic [31:0] sw_wr_nh = '0;
    logic [31:0] sw_wr_oq = '0;
    logic        sw_wr_ack;
    logic        counter_reset = 1'b0;
    logic [31:0] lpm_hit_count;
    logic [31:0] lpm_miss_count;
    logic        dbg_state_commit;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    lpm_table_arbiter #(.NUM_ENTRIES(32), .MAX_WR_WAIT(MAXW)) dut (
        .AXI_ACLK        (clk),
        .AXI_RESET       (rst),
        .lkup_req_valid  (lkup_req_valid),
        .lkup_req_ready  (lkup_req_ready),
        .lkup_ip         (lkup_ip),
        .lkup_resp_valid (lkup_resp_valid),
        .lkup_hit        (lkup_hit),
        .lkup_index      (lkup_index),
        .lkup_nh         (lkup_nh),
        .lkup_oq         (lkup_oq),
        .sw_wr_req       (sw_wr_req),
        .sw_wr_clear     (sw_wr_clear),
        .sw_wr_index     (sw_wr_index),
        .sw_wr_valid     (sw_wr_valid),
        .sw_wr_ip        (sw_wr_ip),
        .sw_wr_mask      (sw_wr_mask),
        .sw_wr_nh        (sw_wr_nh),
        .sw_wr_oq        (sw_wr_oq),
        .sw_wr_ack       (sw_wr_ack),
        .counter_reset   (counter_reset),
        .lpm_hit_count   (lpm_hit_count),
        .lpm_miss_count  (lpm_miss_count),
        .dbg_state_commit(dbg_state_commit)
    );

    // ---------------- reference model ----------------
    logic        m_v    [32];
    logic [31:0] m_ip   [32];
    logic [31:0] m_mask [32];
    logic [31:0] m_nh   [32];
    logic [31:0] m_oq   [32];
    logic        m_commit;      // the current cycle is the commit slot
    int          m_waited;      // lookups let through while a write waits
    logic        m_pend;        // a lookup accepted last cycle
    logic [31:0] m_pend_ip;
    logic [31:0] m_hits, m_misses;
    logic        e_rv, e_hit, e_ack, e_fields;
    logic [4:0]  e_idx;
    logic [31:0] e_nh, e_oq;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_v[i] = 1'b0; m_ip[i] = '0; m_mask[i] = '0; m_nh[i] = '0; m_oq[i] = '0;
        end
        m_commit = 1'b0; m_waited = 0; m_pend = 1'b0; m_pend_ip = '0;
        m_hits = '0; m_misses = '0;
        e_rv = 1'b0; e_hit = 1'b0; e_idx = '0; e_nh = '0; e_oq = '0; e_ack = 1'b0;
    endtask

    // Lowest-index matching route wins; a zero next hop means directly connected.
    task automatic ref_lookup(input logic [31:0] ip, output logic hit, output logic [4:0] idx,
                              output logic [31:0] nh, output logic [31:0] oq);
        hit = 1'b0; idx = '0; nh = '0; oq = '0;
        for (int i = 0; i < 32; i++) begin
            if (!hit && m_v[i] && ((ip & m_mask[i]) == (m_ip[i] & m_mask[i]))) begin
                hit = 1'b1;
                idx = 5'(i);
                nh  = (m_nh[i] == 32'd0) ? ip : m_nh[i];
                oq  = m_oq[i];
            end
        end
    endtask

    // One clock: check ready, advance the model, clock, check outputs.
    task automatic step();
        logic exp_ready, acc, nxt;
        #1;
        exp_ready = !rst && !m_commit && !(sw_wr_req && m_waited == MAXW);
        chk("lkup_req_ready", 32'(lkup_req_ready), 32'(exp_ready));
        acc = lkup_req_valid && exp_ready;
        if (acc) n_acc++;
        if (rst) begin
            model_reset();
            e_fields = 1'b1;
        end else begin
            e_rv = m_pend;
            e_fields = m_pend;
            if (m_pend) ref_lookup(m_pend_ip, e_hit, e_idx, e_nh, e_oq);
            if (counter_reset) begin
                m_hits = '0; m_misses = '0;
            end else if (m_pend) begin
                if (e_hit) m_hits++; else m_misses++;
            end
            if (m_commit) begin
                if (sw_wr_clear) begin
                    for (int i = 0; i < 32; i++) m_v[i] = 1'b0;
                end else begin
                    m_v[sw_wr_index]    = sw_wr_valid;
                    m_ip[sw_wr_index]   = sw_wr_ip;
                    m_mask[sw_wr_index] = sw_wr_mask;
                    m_nh[sw_wr_index]   = sw_wr_nh;
                    m_oq[sw_wr_index]   = sw_wr_oq;
                end
            end
            nxt = !m_commit && sw_wr_req && (!lkup_req_valid || m_waited == MAXW);
            if (m_commit) m_waited = 0;
            else if (sw_wr_req && acc && m_waited < MAXW) m_waited++;
            m_pend    = acc;
            m_pend_ip = lkup_ip;
            m_commit  = nxt;
        end
        e_ack = m_commit;
        @(posedge clk);
        #1;
        chk("resp_valid", 32'(lkup_resp_valid), 32'(e_rv));
        chk("sw_wr_ack", 32'(sw_wr_ack), 32'(e_ack));
        chk("dbg_state", 32'(dbg_state_commit), 32'(e_ack));
        chk("hit_count", lpm_hit_count, m_hits);
        chk("miss_count", lpm_miss_count, m_misses);
        if (e_fields) begin
            chk("lkup_hit", 32'(lkup_hit), 32'(e_hit));
            chk("lkup_index", 32'(lkup_index), 32'(e_idx));
            chk("lkup_nh", lkup_nh, e_nh);
            chk("lkup_oq", lkup_oq, e_oq);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_entry(input logic [4:0] idx, input logic v, input logic [31:0] ip,
                             input logic [31:0] mask, input logic [31:0] nh, input logic [31:0] oq);
        sw_wr_index = idx; sw_wr_valid = v; sw_wr_ip = ip;
        sw_wr_mask = mask; sw_wr_nh = nh; sw_wr_oq = oq; sw_wr_clear = 1'b0;
    endtask

    // Hold the request until the model reaches the commit slot, then drop it.
    task automatic do_write();
        int k;
        sw_wr_req = 1'b1;
        k = 0;
        while (!m_commit && k < 40) begin
            step();
            k++;
        end
        if (!m_commit) begin
            checks++; errors++;
            $error("FAIL write_timeout observed=no_ack expected=ack");
        end
        step();
        sw_wr_req = 1'b0;
        sw_wr_clear = 1'b0;
    endtask

    // Issue one lookup; returns in the cycle its response is on the outputs.
    task automatic lookup(input logic [31:0] ip);
        lkup_req_valid = 1'b1;
        lkup_ip = ip;
        step();
        lkup_req_valid = 1'b0;
        step();
    endtask

    function automatic logic [31:0] pick_ip();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return {24'h0A0001, r[7:0]};
            1:       return {8'h0A, r[23:0]};
            2:       return 32'h0A000107;
            default: return r;
        endcase
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        int acc_start;
        model_reset();
        e_fields = 1'b0;

        // reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // directly connected /24 route
        set_entry(5'd0, 1'b1, 32'h0A000100, 32'hFFFFFF00, 32'h0, 32'd2);
        do_write();
        lookup(32'h0A000107);
        chk("tp1_hit", 32'(lkup_hit), 32'd1);
        chk("tp1_index", 32'(lkup_index), 32'd0);
        chk("tp1_nh", lkup_nh, 32'h0A000107);
        chk("tp1_oq", lkup_oq, 32'd2);
        chk("tp1_hit_count", lpm_hit_count, 32'd1);
        step();

        // /8 route and default route
        set_entry(5'd3, 1'b1, 32'h0A000000, 32'hFF000000, 32'h0A0000FE, 32'd4);
        do_write();
        set_entry(5'd5, 1'b1, 32'h00000000, 32'h00000000, 32'h01020304, 32'd1);
        do_write();
        lookup(32'h0A090909);
        chk("tp2_index", 32'(lkup_index), 32'd3);
        chk("tp2_nh", lkup_nh, 32'h0A0000FE);
        chk("tp2_oq", lkup_oq, 32'd4);
        lookup(32'h08080808);
        chk("tp3_index", 32'(lkup_index), 32'd5);
        chk("tp3_nh", lkup_nh, 32'h01020304);
        chk("tp3_oq", lkup_oq, 32'd1);
        step();

        // randomized lookup traffic with occasional counter clears
        for (int i = 0; i < 80; i++) begin
            lkup_req_valid = ($urandom_range(0, 3) != 0);
            lkup_ip = pick_ip();
            counter_reset = ($urandom_range(0, 19) == 0);
            step();
        end
        lkup_req_valid = 1'b0;
        counter_reset = 1'b0;
        step();
        step();

        // continuous lookups with a write held pending
        set_entry(5'd5, 1'b1, 32'h00000000, 32'h00000000, 32'h01020304, 32'd7);
        sw_wr_req = 1'b1;
        acc_start = n_acc;
        k = 0;
        while (!m_commit && k < 40) begin
            lkup_req_valid = 1'b1;
            lkup_ip = pick_ip();
            step();
            k++;
        end
        chk("b2b_accepted", 32'(n_acc - acc_start), 32'd16);
        chk("b2b_ack_latency", 32'(k), 32'(MAXW + 1));
        step();
        sw_wr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            lkup_ip = pick_ip();
            step();
        end
        lkup_req_valid = 1'b0;
        step();
        step();

        // write lands while an earlier lookup to the same entry resolves
        set_entry(5'd0, 1'b1, 32'h0A000100, 32'hFFFFFF00, 32'h0, 32'd9);
        sw_wr_req = 1'b1;
        lkup_req_valid = 1'b1;
        lkup_ip = 32'h0A000107;
        step();
        lkup_req_valid = 1'b0;
        step();
        chk("old_oq", lkup_oq, 32'd2);
        chk("old_ack", 32'(sw_wr_ack), 32'd1);
        step();
        sw_wr_req = 1'b0;
        lookup(32'h0A000107);
        chk("new_oq", lkup_oq, 32'd9);
        step();

        // clear the table
        sw_wr_clear = 1'b1;
        sw_wr_req = 1'b1;
        step();
        chk("clear_ack", 32'(sw_wr_ack), 32'd1);
        step();
        sw_wr_req = 1'b0;
        sw_wr_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            lkup_req_valid = 1'b1;
            lkup_ip = pick_ip();
            step();
            if (e_rv) chk("clear_miss", 32'(lkup_hit), 32'd0);
        end
        lkup_req_valid = 1'b0;
        step();
        step();

        // reset with lookups in flight and a write pending
        set_entry(5'd3, 1'b1, 32'h0A000000, 32'hFF000000, 32'h0A0000FE, 32'd4);
        do_write();
        set_entry(5'd1, 1'b1, 32'hC0A80000, 32'hFFFF0000, 32'h0, 32'd6);
        sw_wr_req = 1'b1;
        lkup_req_valid = 1'b1;
        lkup_ip = 32'h0A010203;
        step();
        lkup_ip = 32'h0A040506;
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sw_wr_req = 1'b0;
        lkup_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_reset_resp", 32'(lkup_resp_valid), 32'd0);
            chk("post_reset_ack", 32'(sw_wr_ack), 32'd0);
        end

        // miss counter wraps from all-ones
        force dut.lpm_miss_count = 32'hFFFFFFFF;
        #1;
        release dut.lpm_miss_count;
        m_misses = 32'hFFFFFFFF;
        lookup(32'h0A000107);
        chk("wrap_miss_count", lpm_miss_count, 32'd0);
        chk("wrap_hit", 32'(lkup_hit), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
